// File: rtl/mux_4to1_pkg.sv
// Shared select encoding for the 4-way mux and anything that drives its selects.
package mux_4to1_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_I0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_I1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_I2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4to1_mux_2to1.sv
// WIDTH-bit 2:1 mux leaf; an unknown select yields X rather than quietly picking a side.
module mux_2to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = 'x;
    case (i_sel)
      1'b0:    o_y = i_a;
      1'b1:    o_y = i_b;
      default: o_y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 WIDTH-bit mux built as a tree of 2:1 leaves, with a combinational output
// and an enabled, asynchronously cleared registered copy.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [SEL_W-1:0] w_sel;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;

  assign w_sel = {s1, s0};

  // First level picks within each pair on the LSB, second level picks the pair on the MSB.
  mux_2to1 #(.WIDTH(WIDTH)) u_mux_lo (
    .i_a   (i0),
    .i_b   (i1),
    .i_sel (w_sel[0]),
    .o_y   (w_lo)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_mux_hi (
    .i_a   (i2),
    .i_b   (i3),
    .i_sel (w_sel[0]),
    .o_y   (w_hi)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_mux_out (
    .i_a   (w_lo),
    .i_b   (w_hi),
    .i_sel (w_sel[1]),
    .o_y   (w_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
    end else if (en) begin
      r_out_q <= w_out;
    end
  end

  assign out   = w_out;
  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 at WIDTH=1 and WIDTH=8 sharing clock, reset and selects.
module tb_mux_4to1;
  import mux_4to1_pkg::*;

  logic       clk;
  logic       rst;
  logic       s1;
  logic       s0;
  logic       en;
  logic [0:0] a0, a1, a2, a3;
  logic [0:0] out1, outq1;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] out8, outq8;

  logic [7:0] exp_q[$];
  logic [0:0] m_q1;
  logic [7:0] m_q8;
  int         n_checks;
  int         n_errors;

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .i0    (a0),
    .i1    (a1),
    .i2    (a2),
    .i3    (a3),
    .s1    (s1),
    .s0    (s0),
    .en    (en),
    .out   (out1),
    .out_q (outq1)
  );

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .i0    (b0),
    .i1    (b1),
    .i2    (b2),
    .i3    (b3),
    .s1    (s1),
    .s0    (s0),
    .en    (en),
    .out   (out8),
    .out_q (outq8)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] x0,
                                      input logic [7:0] x1, input logic [7:0] x2,
                                      input logic [7:0] x3);
    case (sel)
      SEL_I0:  return x0;
      SEL_I1:  return x1;
      SEL_I2:  return x2;
      default: return x3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive a select, push expected combinational outputs, then pop and compare.
  task automatic apply_sel(input logic [1:0] sel, input string tag);
    {s1, s0} = sel;
    exp_q.push_back(pick(sel, {7'b0, a0}, {7'b0, a1}, {7'b0, a2}, {7'b0, a3}));
    exp_q.push_back(pick(sel, b0, b1, b2, b3));
    #1;
    check({tag, "_out1"}, {7'b0, out1}, exp_q.pop_front());
    check({tag, "_out8"}, out8, exp_q.pop_front());
  endtask

  // Push expected registered outputs for the coming edge, then compare after it.
  task automatic clock_step(input string tag);
    logic [1:0] sel;
    sel = {s1, s0};
    if (rst) begin
      m_q1 = '0;
      m_q8 = '0;
    end else if (en) begin
      m_q1 = pick(sel, {7'b0, a0}, {7'b0, a1}, {7'b0, a2}, {7'b0, a3})
;
      m_q8 = pick(sel, b0, b1, b2, b3);
    end
    exp_q.push_back({7'b0, m_q1});
    exp_q.push_back(m_q8);
    @(posedge clk);
    #1;
    check({tag, "_q1"}, {7'b0, outq1}, exp_q.pop_front());
    check({tag, "_q8"}, outq8, exp_q.pop_front());
  endtask

  task automatic set_data(input logic [3:0] bits1, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    {a0, a1, a2, a3} = bits1;
    b0 = d0; b1 = d1; b2 = d2; b3 = d3;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_q1 = '0;
    m_q8 = '0;
    rst = 1'b1;
    en  = 1'b0;
    {s1, s0} = 2'b00;
    set_data(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state, before any clock edge
    #2;
    check("rst_out1", {7'b0, out1}, 8'h00);
    check("rst_q1", {7'b0, outq1}, 8'h00);
    check("rst_q8", outq8, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Pattern 0101 and 1001 sweeps in 10 ns steps; 8-bit lane carries distinct bytes
    set_data(4'b0101, 8'hA5, 8'h3C, 8'h0F, 8'hF0);
    for (int s = 0; s < 4; s++) begin
      apply_sel(s[1:0], "p0101");
      #9;
    end
    set_data(4'b1001, 8'h5A, 8'hC3, 8'hF0, 8'h0F);
    for (int s = 0; s < 4; s++) begin
      apply_sel(s[1:0], "p1001");
      #9;
    end
    // en=0 throughout the sweeps, so out_q must still be clear
    @(negedge clk);
    clock_step("hold_zero");

    // Capture i1 then hold with en low while the selected input changes
    @(negedge clk);
    set_data(4'b0100, 8'hA5, 8'h3C, 8'h0F, 8'hF0);
    en = 1'b1;
    {s1, s0} = SEL_I1;
    clock_step("cap_i1");
    @(negedge clk);
    en = 1'b0;
    apply_sel(SEL_I0, "sel_i0");
    clock_step("hold_i1");

    // Async reset between edges clears out_q at once; out keeps following inputs
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_q1 = '0;
    m_q8 = '0;
    check("arst_q1", {7'b0, outq1}, 8'h00);
    check("arst_q8", outq8, 8'h00);
    apply_sel(SEL_I3, "arst_sel3");
    en = 1'b1;
    clock_step("arst_en");
    #2;
    rst = 1'b0;
    en  = 1'b0;
    clock_step("post_rst_hold");
    @(negedge clk);
    en = 1'b1;
    clock_step("post_rst_cap");

    // Randomised cycles: random data, select and enable each cycle
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      set_data(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      en = 1'($urandom_range(0, 1));
      apply_sel(2'($urandom_range(0, 3)), "rnd");
      clock_step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
